ack_bus_client: RTL and testbench

- Requester-side agent for the shared open-drain ACK bus. One instance sits inside each module (MEM/SHA/AES/CTRL).
- It counts the module's pending completion acks and raises req toward the bus while any ack is pending.
- It consumes one ack per grant from the arbiter, applies a post-win backoff so lower-priority IDs get a turn, and flags starvation and protocol violations.

---
 rtl/ack_bus_pkg.sv | 32 +++
 rtl/ack_client_fsm.sv | 80 ++++++++
 rtl/ack_bus_client.sv | 103 ++++++++++
 tb/tb_ack_bus_client.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ack_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ack_bus_pkg
// Purpose : Shared definitions for the open-drain ACK bus: source IDs,
//           client FSM state encoding and the grant-qualification helper.
// Rev     : 1.0  initial release
// ============================================================================
package ack_bus_pkg;

    localparam logic [1:0] ID_MEM  = 2'b00;
    localparam logic [1:0] ID_SHA  = 2'b01;
    localparam logic [1:0] ID_AES  = 2'b10;
    localparam logic [1:0] ID_CTRL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_BACKOFF = 2'd2
    } client_state_t;

    // A grant only counts when we are requesting and the arbiter both
    // transferred an ack and named us as the winner.
    function automatic logic is_valid_grant(input logic       req,
                                            input logic       ack_ready,
                                            input logic       ack_event,
                                            input logic [1:0] winner,
                                            input logic [1:0] my_id);
        return req & ack_ready & ack_event & (winner == my_id);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ack_client_fsm.sv
`default_nettype none
// ============================================================================
// Module  : ack_client_fsm
// Purpose : Request/backoff sequencer of the ACK bus client. Holds the state
//           register and the post-win backoff counter.
// Rev     : 1.0  initial release
// ============================================================================
module ack_client_fsm
    import ack_bus_pkg::*;
#(
    parameter int BACKOFF = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ack_push,
    input  logic          pending_nz,
    input  logic          grant,
    input  logic          count_next_nz,
    output client_state_t state
);

    localparam int              BO_W      = (BACKOFF < 2) ? 1 : $clog2(BACKOFF + 1);
    localparam logic [BO_W-1:0] C_BO_LOAD = BO_W'(BACKOFF);
    localparam logic [BO_W-1:0] C_BO_ONE  = BO_W'(1);

    client_state_t   r_state;
    client_state_t   w_state_next;
    logic [BO_W-1:0] r_bo_cnt;
    logic [BO_W-1:0] w_bo_next;

    assign state = r_state;

    // State and backoff counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_bo_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_bo_cnt <= w_bo_next;
        end
    end

    // Next-state decode: request while acks are owed, yield after each win.
    always_comb begin
        w_state_next = r_state;
        w_bo_next    = r_bo_cnt;
        case (r_state)
            ST_IDLE: begin
                if (pending_nz || ack_push) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (grant) begin
                    if (BACKOFF > 0) begin
                        w_state_next = ST_BACKOFF;
                        w_bo_next    = C_BO_LOAD;
                    end else begin
                        w_state_next = count_next_nz ? ST_REQ : ST_IDLE;
                    end
                end
            end
            ST_BACKOFF: begin
                if (r_bo_cnt <= C_BO_ONE) begin
                    w_bo_next    = '0;
                    w_state_next = (pending_nz || ack_push) ? ST_REQ : ST_IDLE;
                end else begin
                    w_bo_next = r_bo_cnt - C_BO_ONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_bo_next    = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ack_bus_client.sv
`default_nettype none
// ============================================================================
// Module  : ack_bus_client
// Purpose : Requester-side agent for the shared ACK bus. Counts owed acks,
//           requests the bus while any are pending, consumes one per grant
//           and flags starvation, dropped pushes and illegal grants.
// Rev     : 1.0  initial release
// ============================================================================
module ack_bus_client
    import ack_bus_pkg::*;
#(
    parameter logic [1:0] MY_ID        = 2'b00,
    parameter int         CNT_W        = 3,
    parameter int         BACKOFF      = 1,
    parameter int         STARVE_LIMIT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ack_push,
    output logic             req,
    input  logic             ack_ready,
    input  logic             ack_event,
    input  logic [1:0]       winner_source_id,
    output logic             ack_done,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             overflow,
    output logic             starved,
    output logic             protocol_err
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [7:0]       C_STARVE  = 8'(STARVE_LIMIT);

    client_state_t    w_state;
    logic             w_grant;
    logic             w_illegal;
    logic             w_drop;
    logic [CNT_W-1:0] w_cnt_next;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_next;

    ack_client_fsm #(
        .BACKOFF (BACKOFF)
    ) u_fsm (
        .clk           (clk),
        .rst_n         (rst_n),
        .ack_push      (ack_push),
        .pending_nz    (pending_cnt != '0),
        .grant         (w_grant),
        .count_next_nz (w_cnt_next != '0),
        .state         (w_state)
    );

    // req is decoded from registered state only, so it cannot glitch.
    assign req       = (w_state == ST_REQ);
    assign w_grant   = is_valid_grant(req, ack_ready, ack_event, winner_source_id, MY_ID);
    assign w_illegal = ack_ready & (~req | ~ack_event | (winner_source_id != MY_ID));

    // Pending count: push and grant cancel; saturate at both ends.
    always_comb begin
        w_cnt_next = pending_cnt;
        w_drop     = 1'b0;
        if (ack_push && !w_grant) begin
            if (pending_cnt == C_CNT_MAX) begin
                w_drop = 1'b1;
            end else begin
                w_cnt_next = pending_cnt + C_CNT_ONE;
            end
        end else if (!ack_push && w_grant && (pending_cnt != '0)) begin
            w_cnt_next = pending_cnt - C_CNT_ONE;
        end
    end

    // Wait counter: counts ungranted REQ cycles, saturating at the limit.
    always_comb begin
        w_wait_next = '0;
        if (req && !w_grant) begin
            w_wait_next = (r_wait_cnt == C_STARVE) ? r_wait_cnt : r_wait_cnt + 8'd1;
        end
    end

    // Counter, wait counter and status flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_cnt  <= '0;
            ack_done     <= 1'b0;
            overflow     <= 1'b0;
            starved      <= 1'b0;
            protocol_err <= 1'b0;
            r_wait_cnt   <= '0;
        end else begin
            pending_cnt  <= w_cnt_next;
            ack_done     <= w_grant;
            overflow     <= overflow | w_drop;
            protocol_err <= protocol_err | w_illegal;
            r_wait_cnt   <= w_wait_next;
            starved      <= (w_wait_next == C_STARVE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ack_bus_client.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_ack_bus_client
// Purpose : Self-checking bench for ack_bus_client: directed scenarios plus
//           randomized bus traffic compared against a behavioural model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ack_bus_client;

    localparam logic [1:0] MY_ID        = 2'b10;
    localparam int         CNT_W        = 3;
    localparam int         BACKOFF      = 1;
    localparam int         STARVE_LIMIT = 15;
    localparam int         CNT_MAX      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ack_push = 1'b0;
    logic             ack_ready = 1'b0;
    logic             ack_event = 1'b0;
    logic [1:0]       winner_source_id = 2'b00;
    logic             req;
    logic             ack_done;
    logic [CNT_W-1:0] pending_cnt;
    logic             overflow;
    logic             starved;
    logic             protocol_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit req;
        bit done;
        bit ovf;
        bit starved;
        bit perr;
        int cnt;
        int cool;
        int waited;
    } model_t;

    model_t m = '{default: 0};

    always #5 clk = ~clk;

    ack_bus_client #(
        .MY_ID        (MY_ID),
        .CNT_W        (CNT_W),
        .BACKOFF      (BACKOFF),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ack_push         (ack_push),
        .req              (req),
        .ack_ready        (ack_ready),
        .ack_event        (ack_event),
        .winner_source_id (winner_source_id),
        .ack_done         (ack_done),
        .pending_cnt      (pending_cnt),
        .overflow         (overflow),
        .starved          (starved),
        .protocol_err     (protocol_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one step of the client, from the rules in words.
    function automatic model_t model_next(input model_t s, input bit push,
                                          input bit rdy, input bit evt,
                                          input logic [1:0] win);
        model_t n;
        bit     grant;
        n     = s;
        grant = s.req && rdy && evt && (win == MY_ID);
        if (rdy && (!s.req || !evt || (win != MY_ID))) n.perr = 1'b1;
        n.done = grant;
        if (push && !grant) begin
            if (s.cnt == CNT_MAX) n.ovf = 1'b1;
            else                  n.cnt = s.cnt + 1;
        end else if (grant && !push && s.cnt > 0) begin
            n.cnt = s.cnt - 1;
        end
        if (s.req && !grant) n.waited = (s.waited < STARVE_LIMIT) ? s.waited + 1 : STARVE_LIMIT;
        else                 n.waited = 0;
        n.starved = (n.waited == STARVE_LIMIT);
        if (s.req) begin
            if (grant) begin
                n.req  = (BACKOFF == 0) ? (n.cnt > 0) : 1'b0;
                n.cool = BACKOFF;
            end
        end else if (s.cool > 0) begin
            n.cool = s.cool - 1;
            if (n.cool == 0) n.req = (s.cnt > 0) || push;
        end else begin
            n.req = (s.cnt > 0) || push;
        end
        return n;
    endfunction

    // Model state advances on the same edges as the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{default: 0};
        else        m <= model_next(m, ack_push, ack_ready, ack_event, winner_source_id);
    end

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        chk("req", req, int'(m.req));
        chk("pending_cnt", pending_cnt, m.cnt);
        chk("ack_done", ack_done, int'(m.done));
        chk("overflow", overflow, int'(m.ovf));
        chk("starved", starved, int'(m.starved));
        chk("protocol_err", protocol_err, int'(m.perr));
    end

    task automatic drive(input bit p, input bit r, input bit e, input logic [1:0] w);
        ack_push         = p;
        ack_ready        = r;
        ack_event        = e;
        winner_source_id = w;
        @(posedge clk);
        #1;
    endtask

    // Bench arbiter: grants this client whenever it requests (if allowed).
    task automatic arb(input bit p, input bit allow);
        if (allow && m.req) drive(p, 1'b1, 1'b1, MY_ID);
        else                drive(p, 1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit [5:0] pat;
        int       dones;
        logic [1:0] w;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_req", req, 0);
        chk("rst_cnt", pending_cnt, 0);
        chk("rst_flags", {ack_done, overflow, starved, protocol_err}, 0);

        // Basic single ack
        arb(1'b1, 1'b1);
        chk("basic_req_c1", req, 1);
        chk("basic_cnt_c1", pending_cnt, 1);
        arb(1'b0, 1'b1);
        chk("basic_done_c2", ack_done, 1);
        chk("basic_cnt_c2", pending_cnt, 0);
        chk("basic_req_c2", req, 0);
        repeat (3) arb(1'b0, 1'b1);
        chk("basic_req_idle", req, 0);

        // Burst of three with backoff between wins
        repeat (3) arb(1'b1, 1'b0);
        chk("burst_peak", pending_cnt, 3);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            pat[5-i] = req;
            arb(1'b0, 1'b1);
            if (ack_done) dones++;
        end
        chk("burst_req_pattern", pat, 6'b101010);
        chk("burst_dones", dones, 3);
        chk("burst_final_cnt", pending_cnt, 0);

        // Loss to ID 00 for four cycles, then win
        arb(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("loss_req", req, 1);
            drive(1'b0, 1'b0, 1'b1, 2'b00);
            chk("loss_cnt", pending_cnt, 1);
        end
        chk("loss_req_last", req, 1);
        arb(1'b0, 1'b1);
        chk("win_done", ack_done, 1);
        chk("win_flags", {starved, protocol_err}, 0);
        repeat (2) arb(1'b0, 1'b1);

        // Starvation
        arb(1'b1, 1'b0);
        repeat (14) drive(1'b0, 1'b0, 1'b0, 2'b00);
        chk("starve_14", starved, 0);
        drive(1'b0, 1'b0, 1'b0, 2'b00);
        chk("starve_15", starved, 1);
        repeat (5) drive(1'b0, 1'b0, 1'b0, 2'b00);
        chk("starve_20", starved, 1);
        arb(1'b0, 1'b1);
        chk("starve_cleared", starved, 0);
        repeat (2) arb(1'b0, 1'b1);

        // Overflow, then push coinciding with a grant
        repeat (8) arb(1'b1, 1'b0);
        chk("ovf_cnt", pending_cnt, 7);
        chk("ovf_flag", overflow, 1);
        arb(1'b1, 1'b1);
        chk("simul_cnt", pending_cnt, 7);
        chk("simul_done", ack_done, 1);
        for (int i = 0; i < 40 && (m.cnt != 0 || m.req); i++) arb(1'b0, 1'b1);
        repeat (2) arb(1'b0, 1'b1);
        chk("drain_cnt", pending_cnt, 0);

        // Grant while not requesting
        drive(1'b0, 1'b1, 1'b0, MY_ID);
        chk("perr_flag", protocol_err, 1);
        chk("perr_cnt", pending_cnt, 0);
        drive(1'b0, 1'b0, 1'b0, 2'b00);

        // Reset in the middle of a request
        arb(1'b1, 1'b0);
        chk("pre_rst_req", req, 1);
        drive(1'b0, 1'b0, 1'b0, 2'b00);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async_req", req, 0);
        chk("rst_async_cnt", pending_cnt, 0);
        chk("rst_async_flags", {ack_done, overflow, starved, protocol_err}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized bus traffic (legal grants and losses only)
        for (int i = 0; i < 2000; i++) begin
            bit p;
            int gdiv;
            p    = ($urandom_range(0, 3) == 0);
            gdiv = (i < 1000) ? 2 : 7;
            if (m.req && $urandom_range(0, gdiv) == 0) begin
                drive(p, 1'b1, 1'b1, MY_ID);
            end else if ($urandom_range(0, 1) == 0) begin
                w = 2'($urandom_range(0, 3));
                if (w == MY_ID) w = 2'b11;
                drive(p, 1'b0, 1'b1, w);
            end else begin
                drive(p, 1'b0, 1'b0, 2'b00);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
